// File: rtl/serial_byte_tx_pkg.sv
// Shared types and framing constants for the oversampled serial link (transmitter and receiver).
package serial_byte_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    localparam int DEF_SAMPLES_PER_BIT = 16;
    localparam int DEF_DATA_W          = 8;
    localparam int FRAME_BITS          = DEF_DATA_W + 2;

    function automatic int frame_clocks(input int data_w, input int samples_per_bit);
        return (data_w + 2) * samples_per_bit;
    endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Per-bit sample counter with clear and enable; tick marks the last clock of a bit.
// Counter is registered, tick is a decode of it qualified by enable; no backpressure.
module tx_bit_timer
    import serial_byte_tx_pkg::*;
#(
    parameter  int SAMPLES_PER_BIT = DEF_SAMPLES_PER_BIT,
    localparam int CNT_W           = $clog2(SAMPLES_PER_BIT)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tick_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLES_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign tick_o = en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/serial_byte_tx.sv
// Serial byte transmitter: start, DATA_W bits LSB first, stop; one-deep hold register, frames back-to-back.
// Start bit begins one clock after load is accepted from idle; load while not empty is dropped with an overrun pulse.
module serial_byte_tx
    import serial_byte_tx_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = DEF_SAMPLES_PER_BIT,
    parameter int DATA_W          = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] dataIn,
    output logic              serialOut,
    output logic              empty,
    output logic              busy,
    output logic              sent,
    output logic              overrun
);

    localparam int CNT_W = $clog2(SAMPLES_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] PRE_LAST_CNT = CNT_W'(SAMPLES_PER_BIT - 2);
    localparam logic [IDX_W-1:0] LAST_BIT     = IDX_W'(DATA_W - 1);

    state_e            state_q;
    logic [IDX_W-1:0]  bit_idx_q;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] shift_q;
    logic              empty_q;
    logic              serial_q;
    logic              sent_q;
    logic              overrun_q;

    logic [CNT_W-1:0]  sample_cnt;
    logic              bit_tick;
    logic              transfer;

    tx_bit_timer #(
        .SAMPLES_PER_BIT(SAMPLES_PER_BIT)
    ) u_bit_timer (
        .clock  (clock),
        .reset  (reset),
        .clr_i  (state_q == IDLE),
        .en_i   (state_q != IDLE),
        .cnt_o  (sample_cnt),
        .tick_o (bit_tick)
    );

    // The hold register empties only on the edge that starts a frame, from idle or at the end of a stop bit.
    assign transfer = !empty_q && ((state_q == IDLE) || ((state_q == STOP) && bit_tick));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            hold_q    <= '0;
            shift_q   <= '0;
            empty_q   <= 1'b1;
            serial_q  <= IDLE_LEVEL;
            sent_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= load && !empty_q;
            // Registered, so decode one clock early to land on the last clock of the stop bit.
            sent_q    <= (state_q == STOP) && (sample_cnt == PRE_LAST_CNT);

            if (load && empty_q) begin
                hold_q  <= dataIn;
                empty_q <= 1'b0;
            end else if (transfer) begin
                empty_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    serial_q <= IDLE_LEVEL;
                    if (transfer) begin
                        shift_q  <= hold_q;
                        state_q  <= START;
                        serial_q <= START_LEVEL;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        state_q   <= DATA;
                        bit_idx_q <= '0;
                        serial_q  <= shift_q[0];
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shift_q <= shift_q >> 1;
                        if (bit_idx_q == LAST_BIT) begin
                            state_q  <= STOP;
                            serial_q <= STOP_LEVEL;
                        end else begin
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                            serial_q  <= shift_q[1];
                        end
                    end
                end
                STOP: begin
                    if (transfer) begin
                        shift_q  <= hold_q;
                        state_q  <= START;
                        serial_q <= START_LEVEL;
                    end else if (bit_tick) begin
                        state_q  <= IDLE;
                        serial_q <= IDLE_LEVEL;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    serial_q <= IDLE_LEVEL;
                end
            endcase
        end
    end

    assign serialOut = serial_q;
    assign empty     = empty_q;
    assign busy      = (state_q != IDLE);
    assign sent      = sent_q;
    assign overrun   = overrun_q;

endmodule
